// File: rtl/chacha20_top.sv
// Iterative ChaCha20 block function (RFC 8439): one round, i.e. four parallel
// quarter-rounds, per clock, followed by the feed-forward add and byte serialization.

module chacha20_qr (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    output logic [31:0] qa,
    output logic [31:0] qb,
    output logic [31:0] qc,
    output logic [31:0] qd
);
    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    logic [31:0] a1, b1, c1, d1;

    assign a1 = a + b;
    assign d1 = rotl(d ^ a1, 16);
    assign c1 = c + d1;
    assign b1 = rotl(b ^ c1, 12);
    assign qa = a1 + b1;
    assign qd = rotl(d1 ^ qa, 8);
    assign qc = c1 + qd;
    assign qb = rotl(b1 ^ qc, 7);
endmodule

module chacha20_top #(
    parameter int ROUNDS = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [31:0]  counter,
    input  logic [95:0]  nonce,
    output logic [511:0] keystream,
    output logic         done
);
    localparam int RW = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    state_t             state, state_nxt;
    logic [RW-1:0]      rnd;
    logic [15:0][31:0]  work, init, init_ld, work_rnd;
    logic [3:0][3:0]    ib, ic, id;
    logic [3:0][31:0]   qa, qb, qc, qd;
    logic [511:0]       ks_nxt;
    logic               diag;

    // Odd rounds are diagonal: lane j rotates its b/c/d picks by 1/2/3 columns.
    assign diag = rnd[0];

    for (genvar j = 0; j < 4; j++) begin : g_lane
        assign ib[j] = {2'b01, diag ? 2'(j + 1) : 2'(j)};
        assign ic[j] = {2'b10, diag ? 2'(j + 2) : 2'(j)};
        assign id[j] = {2'b11, diag ? 2'(j + 3) : 2'(j)};

        chacha20_qr u_qr (
            .a  (work[j]),
            .b  (work[ib[j]]),
            .c  (work[ic[j]]),
            .d  (work[id[j]]),
            .qa (qa[j]),
            .qb (qb[j]),
            .qc (qc[j]),
            .qd (qd[j])
        );
    end

    always_comb begin
        work_rnd = work;
        for (int j = 0; j < 4; j++) begin
            work_rnd[j]     = qa[j];
            work_rnd[ib[j]] = qb[j];
            work_rnd[ic[j]] = qc[j];
            work_rnd[id[j]] = qd[j];
        end
    end

    // Key and nonce bytes arrive big-endian in the bus; state words are little-endian.
    always_comb begin
        init_ld     = '0;
        init_ld[0]  = 32'h61707865;
        init_ld[1]  = 32'h3320646e;
        init_ld[2]  = 32'h79622d32;
        init_ld[3]  = 32'h6b206574;
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 4; k++)
                init_ld[4+i][8*k +: 8] = key[255 - 8*(4*i + k) -: 8];
        init_ld[12] = counter;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 4; k++)
                init_ld[13+i][8*k +: 8] = nonce[95 - 8*(4*i + k) -: 8];
    end

    always_comb begin
        logic [31:0] sum;
        ks_nxt = '0;
        for (int i = 0; i < 16; i++) begin
            sum = work[i] + init[i];
            for (int k = 0; k < 4; k++)
                ks_nxt[511 - 8*(4*i + k) -: 8] = sum[8*k +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ROUND;
            ROUND:   if (rnd == RW'(ROUNDS - 1)) state_nxt = FINAL;
            FINAL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            work      <= '0;
            init      <= '0;
            rnd       <= '0;
            keystream <= '0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    work <= init_ld;
                    init <= init_ld;
                    rnd  <= '0;
                    done <= 1'b0;
                end
                ROUND: begin
                    work <= work_rnd;
                    rnd  <= rnd + 1'b1;
                end
                FINAL: begin
                    keystream <= ks_nxt;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_chacha20_top.sv
// Randomized and RFC-vector bench for chacha20_top against a plain block-function model.

module tb_chacha20_top;
    logic         clk = 1'b0;
    logic         reset, start;
    logic [255:0] key;
    logic [31:0]  counter;
    logic [95:0]  nonce;
    logic [511:0] keystream;
    logic         done;

    int tests = 0;
    int fails = 0;

    localparam logic [255:0] RFC_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [95:0]  RFC_NONCE = 96'h000000090000004a00000000;
    localparam logic [511:0] RFC_KS =
        512'h10f1e7e4d13b5915500fdd1fa32071c4c7d1f4c733c068030422aa9ac3d46c4ed2826446079faa0914c2d705d98b02a2b5129cd1de164eb9cbd083e8a2503c4e;

    always #5 clk = ~clk;

    chacha20_top dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .key       (key),
        .counter   (counter),
        .nonce     (nonce),
        .keystream (keystream),
        .done      (done)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Straight from the RFC: bytes -> LE words, 10 double rounds, add, LE bytes out.
    function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [31:0] c,
                                               input logic [95:0] n);
        logic [7:0]   kb[32];
        logic [7:0]   nb[12];
        logic [31:0]  s[16];
        logic [31:0]  x[16];
        logic [31:0]  o;
        logic [511:0] res;
        int           qi[8][4];
        int           a, b, cc, d;
        qi = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
               '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
        for (int j = 0; j < 32; j++) kb[j] = k[255 - 8*j -: 8];
        for (int j = 0; j < 12; j++) nb[j] = n[95 - 8*j -: 8];
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = {kb[4*i+3], kb[4*i+2], kb[4*i+1], kb[4*i]};
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13+i] = {nb[4*i+3], nb[4*i+2], nb[4*i+1], nb[4*i]};
        x = s;
        for (int r = 0; r < 10; r++)
            for (int q = 0; q < 8; q++) begin
                a = qi[q][0]; b = qi[q][1]; cc = qi[q][2]; d = qi[q][3];
                x[a] += x[b];  x[d] = rotl(x[d] ^ x[a], 16);
                x[cc] += x[d]; x[b] = rotl(x[b] ^ x[cc], 12);
                x[a] += x[b];  x[d] = rotl(x[d] ^ x[a], 8);
                x[cc] += x[d]; x[b] = rotl(x[b] ^ x[cc], 7);
            end
        res = '0;
        for (int i = 0; i < 16; i++) begin
            o = x[i] + s[i];
            for (int j = 0; j < 4; j++) res[511 - 8*(4*i + j) -: 8] = o[8*j +: 8];
        end
        return res;
    endfunction

    // Pulse start, then count cycles until done (bounded). lat=-1 when aborted by reset.
    task automatic run_block(input logic [255:0] k, input logic [31:0] c, input logic [95:0] n,
                             input bit busy, input bit rst_mid, output int lat);
        key = k; counter = c; nonce = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_clr", 512'(done), 512'(0));
        lat = 0;
        while (!done && lat < 40) begin
            if (busy && (lat == 5 || lat == 15)) begin
                start = 1'b1;
                key   = {8{$urandom()}};
            end else begin
                start = 1'b0;
            end
            if (rst_mid && lat == 10) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("rst_done", 512'(done), 512'(0));
                check("rst_ks", keystream, 512'(0));
                lat = -1;
                return;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    initial begin
        int           lat;
        logic [511:0] held;
        logic [255:0] rk;
        logic [95:0]  rn;
        logic [31:0]  rc;

        reset = 1'b1; start = 1'b0; key = '0; counter = '0; nonce = '0;
        repeat (2) @(negedge clk);
        check("reset_done", 512'(done), 512'(0));
        check("reset_ks", keystream, 512'(0));
        reset = 1'b0;
        @(negedge clk);

        run_block(RFC_KEY, 32'd1, RFC_NONCE, 1'b0, 1'b0, lat);
        check("rfc_lat", 512'(lat), 512'(21));
        check("rfc_ks", keystream, RFC_KS);
        check("rfc_model", keystream, ref_block(RFC_KEY, 32'd1, RFC_NONCE));

        held = keystream;
        for (int i = 0; i < 10; i++) begin
            key = {8{$urandom()}}; nonce = {3{$urandom()}}; counter = $urandom();
            @(negedge clk);
            check("hold_done", 512'(done), 512'(1));
            check("hold_ks", keystream, held);
        end

        run_block('0, 32'd0, '0, 1'b0, 1'b0, lat);
        check("zero_lat", 512'(lat), 512'(21));
        check("zero_head", 512'(keystream[511:448]), 512'(64'h76b8e0ada0f13d90));
        check("zero_tail", 512'(keystream[31:0]), 512'(32'hb2ee6586));

        run_block(RFC_KEY, 32'd1, RFC_NONCE, 1'b1, 1'b0, lat);
        check("busy_lat", 512'(lat), 512'(21));
        check("busy_ks", keystream, RFC_KS);

        run_block(RFC_KEY, 32'd1, RFC_NONCE, 1'b0, 1'b1, lat);
        check("rst_abort", 512'(lat), 512'(-1));
        run_block(RFC_KEY, 32'd1, RFC_NONCE, 1'b0, 1'b0, lat);
        check("post_rst_lat", 512'(lat), 512'(21));
        check("post_rst_ks", keystream, RFC_KS);

        run_block(RFC_KEY, 32'd2, RFC_NONCE, 1'b0, 1'b0, lat);
        check("b2b_lat", 512'(lat), 512'(21));
        check("b2b_ks", keystream, ref_block(RFC_KEY, 32'd2, RFC_NONCE));
        check("b2b_differs", 512'(keystream != RFC_KS), 512'(1));

        for (int t = 0; t < 8; t++) begin
            rk = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
            rn = {$urandom(), $urandom(), $urandom()};
            rc = (t == 0) ? 32'hffffffff : $urandom();
            run_block(rk, rc, rn, 1'b0, 1'b0, lat);
            check("rand_lat", 512'(lat), 512'(21));
            check("rand_ks", keystream, ref_block(rk, rc, rn));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
